a2d_scan_sched: RTL and testbench

- Sequences the shared A2D SPI interface (strt_cnv/chnnl/cnv_cmplt/res).
- Runs periodic round-robin scans over a channel enable mask and stores the latest result per channel.
- Also services one-shot conversion requests from a single external requester; those take priority between scan conversions.
- Sits between sensor-consuming logic and the A2D interface. The top level ties the interface's rst_n to ~rst.

---
 rtl/a2d_pkg.sv | 11 +
 rtl/a2d_period_tmr.sv | 25 ++
 rtl/a2d_scan_sched.sv | 141 ++++++++++++++
 tb/tb_a2d_scan_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and widths for the A2D scan scheduler.
//   CH_W          - width of an A2D channel select
//   RES_W         - width of an A2D conversion result
//   sched_state_t - scheduler FSM states
//   conv_kind_t   - origin of the conversion in flight
package a2d_pkg;
    localparam int CH_W  = 3;
    localparam int RES_W = 12;
    typedef enum logic [1:0] {IDLE, ISSUE, CONV} sched_state_t;
    typedef enum logic {SCAN, ONESHOT} conv_kind_t;
endpackage

// File: rtl/a2d_period_tmr.sv
// a2d_period_tmr: free-running down-counter that pulses o_trig once every PERIOD_CYC clocks.
//   clk    - system clock
//   rst    - asynchronous active-high reset, loads PERIOD_CYC-1
//   o_trig - one-cycle pulse while the count sits at zero
module a2d_period_tmr #(
    parameter int PERIOD_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic o_trig
);
    localparam int CW = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LOAD = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= LOAD;
        else
            r_cnt <= (r_cnt == '0) ? LOAD : r_cnt - 1'b1;
    end

    assign o_trig = (r_cnt == '0);
endmodule

// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched: shares one A2D SPI interface between periodic round-robin scans and one-shot requests.
//   clk, rst                  - system clock, asynchronous active-high reset
//   i_en_mask                 - per-channel scan enable, latched at each scan start
//   i_req/i_req_chnl          - one-shot request (level) and its channel
//   o_req_ack/o_req_res       - one-shot completion pulse and result
//   i_rd_chnl/o_rd_res        - combinational readback of the stored scan results
//   o_scan_done               - pulse when the last channel of a scan completes
//   o_ovr/i_clr_ovr           - sticky overrun flag and its clear
//   o_strt_cnv/o_chnnl        - conversion start and channel to the A2D interface
//   i_cnv_cmplt/i_res         - conversion complete and result from the A2D interface
module a2d_scan_sched
    import a2d_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int PERIOD_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_en_mask,
    input  logic              i_req,
    input  logic [CH_W-1:0]   i_req_chnl,
    output logic              o_req_ack,
    output logic [RES_W-1:0]  o_req_res,
    input  logic [CH_W-1:0]   i_rd_chnl,
    output logic [RES_W-1:0]  o_rd_res,
    output logic              o_scan_done,
    output logic              o_ovr,
    input  logic              i_clr_ovr,
    output logic              o_strt_cnv,
    output logic [CH_W-1:0]   o_chnnl,
    input  logic              i_cnv_cmplt,
    input  logic [RES_W-1:0]  i_res
);
    sched_state_t      r_state;
    conv_kind_t        r_kind;
    logic [NUM_CH-1:0] r_scan_mask;
    logic              r_scan_active;
    logic [CH_W:0]     r_ptr;
    logic              r_ovr;
    logic              r_strt_cnv;
    logic [CH_W-1:0]   r_chnnl;
    logic [RES_W-1:0]  r_req_res;
    logic [RES_W-1:0]  r_res [NUM_CH];

    logic              w_trig;
    logic              w_cnv_end;
    logic              w_found;
    logic              w_more;
    logic [CH_W-1:0]   w_sel;

    a2d_period_tmr #(.PERIOD_CYC(PERIOD_CYC)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .o_trig (w_trig)
    );

    // w_sel: lowest enabled channel at or above the scan pointer.
    // w_more: some enabled channel lies above the one currently converting.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_more  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_scan_mask[i] && i >= int'(r_ptr)) begin
                w_sel   = CH_W'(i);
                w_found = 1'b1;
            end
            if (r_scan_mask[i] && i > int'(r_chnnl))
                w_more = 1'b1;
        end
    end

    assign w_cnv_end   = (r_state == CONV) && i_cnv_cmplt;
    assign o_req_ack   = w_cnv_end && (r_kind == ONESHOT);
    assign o_scan_done = w_cnv_end && (r_kind == SCAN) && !w_more;
    // The fresh result is forwarded during the acknowledge cycle itself.
    assign o_req_res   = o_req_ack ? i_res : r_req_res;
    assign o_rd_res    = (int'(i_rd_chnl) < NUM_CH) ? r_res[i_rd_chnl] : '0;
    assign o_ovr       = r_ovr;
    assign o_strt_cnv  = r_strt_cnv;
    assign o_chnnl     = r_chnnl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_kind        <= SCAN;
            r_scan_mask   <= '0;
            r_scan_active <= 1'b0;
            r_ptr         <= '0;
            r_ovr         <= 1'b0;
            r_strt_cnv    <= 1'b0;
            r_chnnl       <= '0;
            r_req_res     <= '0;
        end else begin
            r_strt_cnv <= (r_state == ISSUE);
            // A new overrun beats a simultaneous clear.
            r_ovr <= (w_trig && r_scan_active) || (r_ovr && !i_clr_ovr);
            if (w_trig && !r_scan_active && |i_en_mask) begin
                r_scan_mask   <= i_en_mask;
                r_scan_active <= 1'b1;
                r_ptr         <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_chnnl <= i_req_chnl;
                        r_kind  <= ONESHOT;
                        r_state <= ISSUE;
                    end else if (r_scan_active && w_found) begin
                        r_chnnl <= w_sel;
                        r_kind  <= SCAN;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= CONV;
                CONV: begin
                    if (i_cnv_cmplt) begin
                        r_state <= IDLE;
                        if (r_kind == ONESHOT) begin
                            r_req_res <= i_res;
                        end else begin
                            r_ptr <= (CH_W+1)'(r_chnnl) + 1'b1;
                            if (!w_more)
                                r_scan_active <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                r_res[i] <= '0;
        end else if (w_cnv_end && r_kind == SCAN) begin
            r_res[r_chnnl] <= i_res;
        end
    end
endmodule

// File: tb/tb_a2d_scan_sched.sv
// tb_a2d_scan_sched: scoreboard bench for a2d_scan_sched with a behavioural 40-cycle A2D model.
module tb_a2d_scan_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  en_mask;
    logic        req;
    logic [2:0]  req_chnl;
    logic        req_ack;
    logic [11:0] req_res;
    logic [2:0]  rd_chnl;
    logic [11:0] rd_res;
    logic        scan_done;
    logic        ovr;
    logic        clr_ovr;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    logic [2:0]  exp_ch [$];
    logic [11:0] exp_rr [$];

    a2d_scan_sched #(.NUM_CH(8), .PERIOD_CYC(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en_mask   (en_mask),
        .i_req       (req),
        .i_req_chnl  (req_chnl),
        .o_req_ack   (req_ack),
        .o_req_res   (req_res),
        .i_rd_chnl   (rd_chnl),
        .o_rd_res    (rd_res),
        .o_scan_done (scan_done),
        .o_ovr       (ovr),
        .i_clr_ovr   (clr_ovr),
        .o_strt_cnv  (strt_cnv),
        .o_chnnl     (chnnl),
        .i_cnv_cmplt (cnv_cmplt),
        .i_res       (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_strt(input logic [2:0] ch, input int lim, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(strt_cnv && chnnl == ch) && k < lim);
        chk(name, 32'(strt_cnv && chnnl == ch), 1);
    endtask

    task automatic wait_done(input int n, input int lim, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (n_done < n && k < lim);
        chk(name, n_done, n);
    endtask

    task automatic rd_chk(input logic [2:0] ch, input logic [11:0] exp, input string name);
        step();
        rd_chnl = ch;
        @(negedge clk);
        chk($sformatf("%s_ch%0d", name, ch), rd_res, exp);
    endtask

    task automatic clear_ovr(input string name);
        step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        @(negedge clk);
        chk(name, ovr, 0);
    endtask

    // A2D model: result equals the channel number, 40 cycles after strt_cnv.
    initial begin
        logic [2:0] m_ch;
        int m_k;
        cnv_cmplt = 1'b0;
        res = '0;
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                m_ch = chnnl;
                m_k = 0;
                while (m_k < 40 && !rst) begin
                    @(posedge clk);
                    #2;
                    m_k++;
                end
                if (!rst) begin
                    res = {9'h0, m_ch};
                    cnv_cmplt = 1'b1;
                    @(posedge clk);
                    #2;
                    cnv_cmplt = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (strt_cnv) begin
            checks++;
            if (exp_ch.size() == 0) begin
                errors++;
                $display("FAIL strt_cnv: unexpected start on chnnl %0d", chnnl);
            end else begin
                e = exp_ch.pop_front();
                if (chnnl !== e) begin
                    errors++;
                    $display("FAIL strt_chnnl: got %0d expected %0d", chnnl, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (req_ack) begin
            checks++;
            if (exp_rr.size() == 0) begin
                errors++;
                $display("FAIL req_ack: unexpected ack with req_res %0d", req_res);
            end else begin
                e = exp_rr.pop_front();
                if (req_res !== e) begin
                    errors++;
                    $display("FAIL req_res: got %0d expected %0d", req_res, e);
                end
            end
        end
        if (scan_done)
            n_done++;
    end

    initial begin
        logic [11:0] t1_exp [8] = '{12'd0, 12'd0, 12'd2, 12'd0, 12'd0, 12'd5, 12'd0, 12'd7};
        int t;
        int r;
        rst = 1'b1;
        en_mask = 8'hA5;
        req = 1'b0;
        req_chnl = '0;
        rd_chnl = '0;
        clr_ovr = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_strt_cnv", strt_cnv, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_req_res", req_res, 0);
        chk("rst_chnnl", chnnl, 0);
        for (int i = 0; i < 8; i++) rd_chk(3'(i), 12'd0, "rst_rd");

        // Scan over 8'hA5
        exp_ch.push_back(0); exp_ch.push_back(2); exp_ch.push_back(5); exp_ch.push_back(7);
        step();
        rst = 1'b0;
        wait_strt(0, 150, "t1_first_strt");
        step();
        en_mask = 8'h00;
        wait_done(1, 400, "t1_scan_done");
        for (int i = 0; i < 8; i++) rd_chk(3'(i), t1_exp[i], "t1_rd");
        clear_ovr("t1_clr_ovr");

        // Three periods with nothing enabled
        repeat (300) step();
        @(negedge clk);
        #1;
        chk("t3_no_scan_done", n_done, 1);
        chk("t3_no_ovr", ovr, 0);

        // One-shot on ch3 arriving during the ch2 scan conversion
        exp_ch.push_back(0); exp_ch.push_back(2); exp_ch.push_back(3);
        exp_ch.push_back(5); exp_ch.push_back(7);
        exp_rr.push_back(12'h003);
        step();
        en_mask = 8'hA5;
        wait_strt(0, 150, "t2_first_strt");
        step();
        en_mask = 8'h00;
        wait_strt(2, 150, "t2_ch2_strt");
        step();
        req = 1'b1;
        req_chnl = 3'd3;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!req_ack && k < 150);
            chk("t2_req_ack_seen", req_ack, 1);
        end
        step();
        req = 1'b0;
        wait_done(2, 400, "t2_scan_done");
        rd_chk(3'd3, 12'd0, "t2_rd_oneshot_untouched");
        rd_chk(3'd5, 12'd5, "t2_rd");
        chk("t2_req_res_held", req_res, 12'h003);
        clear_ovr("t2_clr_ovr");

        // Overrun, clear, and clear colliding with a new overrun
        for (int i = 0; i < 8; i++) exp_ch.push_back(3'(i));
        step();
        en_mask = 8'hFF;
        wait_strt(0, 150, "t4_first_strt");
        step();
        en_mask = 8'h00;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!ovr && k < 150);
            chk("t4_ovr_set", ovr, 1);
        end
        t = cyc;
        clear_ovr("t4_ovr_clr");
        do step(); while (cyc != t + 99);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", ovr, 1);
        wait_done(3, 500, "t4_scan_done");
        rd_chk(3'd1, 12'd1, "t4_rd");
        rd_chk(3'd4, 12'd4, "t4_rd");
        rd_chk(3'd6, 12'd6, "t4_rd");
        clear_ovr("t4_clr_ovr_end");

        // en_mask change mid-scan applies to the next scan only
        for (int i = 0; i < 8; i++) exp_ch.push_back(3'(i));
        step();
        en_mask = 8'h0F;
        wait_strt(0, 150, "t5_first_strt");
        step();
        en_mask = 8'hF0;
        wait_strt(4, 300, "t5_second_scan");
        step();
        en_mask = 8'h00;
        wait_done(5, 400, "t5_scan_done");
        clear_ovr("t5_clr_ovr");

        // Reset in the middle of a conversion
        exp_ch.push_back(0);
        step();
        en_mask = 8'hFF;
        wait_strt(0, 150, "t6_first_strt");
        step();
        en_mask = 8'h00;
        repeat (10) step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_strt_cnv", strt_cnv, 0);
        chk("t6_rst_scan_done", scan_done, 0);
        chk("t6_rst_chnnl", chnnl, 0);
        for (int i = 0; i < 8; i++) rd_chk(3'(i), 12'd0, "t6_rst_rd");
        step();
        rst = 1'b0;
        en_mask = 8'h01;
        r = cyc;
        exp_ch.push_back(0);
        wait_strt(0, 150, "t6_post_rst_strt");
        chk("t6_post_rst_latency", cyc - r, 102);
        step();
        en_mask = 8'h00;
        wait_done(6, 200, "t6_scan_done");

        repeat (5) step();
        chk("end_exp_ch_empty", exp_ch.size(), 0);
        chk("end_exp_rr_empty", exp_rr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
